jtbubl_romarb: RTL

Five-slot SDRAM read scheduler for the Bubble Bobble/Tokio core. It shares the single SDRAM read port between the main, sub, MCU, sound and graphics ROM requesters, and keeps one 32-bit cache line per slot. It sits between the CPU/video ROM interfaces and the SDRAM controller, and is idle while ROM download is in progress.

---
 rtl/jtbubl_pkg.sv | 33 +++
 rtl/jtbubl_romarb_line.sv | 81 ++++++++
 rtl/jtbubl_romarb.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/jtbubl_pkg.sv
// Shared definitions for the Bubble Bobble / Tokio SDRAM ROM read scheduler.
//   arb_state_e       : arbiter FSM encoding (IDLE, REQ, WAIT, FILL)
//   SLOT_CNT          : number of ROM requesters sharing the SDRAM read port
//   SLOTn_OFFSET_DEF  : default SDRAM word offsets, also used by the game top-level
//   sdram_word()      : turns a 32-bit line address into a 16-bit SDRAM word address
package jtbubl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FILL = 2'd3
  } arb_state_e;

  localparam int SLOT_CNT = 5;

  // Widest requester address; the latched request address is held at this width.
  localparam int REQ_AW = 18;

  localparam logic [21:0] SLOT0_OFFSET_DEF = 22'h0_0000;
  localparam logic [21:0] SLOT1_OFFSET_DEF = 22'h1_4000;
  localparam logic [21:0] SLOT2_OFFSET_DEF = 22'h1_C000;
  localparam logic [21:0] SLOT3_OFFSET_DEF = 22'h1_8000;
  localparam logic [21:0] SLOT4_OFFSET_DEF = 22'h2_0000;

  // One cache line spans two 16-bit SDRAM words, so the line index is doubled.
  // The sum wraps at 22 bits by design.
  function automatic logic [21:0] sdram_word(input logic [21:0] offset,
                                             input logic [21:0] line_addr);
    return offset + {line_addr[20:0], 1'b0};
  endfunction

endpackage

// File: rtl/jtbubl_romarb_line.sv
// One 32-bit cache line of the ROM read scheduler.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   cs_i, addr_i      : requester strobe and address (byte address when DW=8,
//                       32-bit word address when DW=32)
//   clr_i             : invalidate the line
//   fill_i            : write the line from fill_addr_i / fill_data_i
//   miss_o            : request present and line does not hold it
//   ok_o, dout_o      : registered hit flag and data
module jtbubl_romarb_line #(
  parameter int AW = 18,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cs_i,
  input  logic [AW-1:0] addr_i,
  input  logic          clr_i,
  input  logic          fill_i,
  input  logic [AW-1:0] fill_addr_i,
  input  logic [31:0]   fill_data_i,
  output logic          miss_o,
  output logic          ok_o,
  output logic [DW-1:0] dout_o
);

  // Byte-wide slots tag on the line index; the gfx slot tags on the full word address.
  localparam bit BYTE_SLOT = (DW == 8);
  localparam int LSB       = BYTE_SLOT ? 2 : 0;
  localparam int TW        = AW - LSB;

  logic          valid_q;
  logic [TW-1:0] tag_q;
  logic [31:0]   data_q;
  logic          ok_q, ok_d;
  logic [DW-1:0] dout_q, dout_d;

  logic [TW-1:0] cur_tag, fill_tag;
  logic          hit_cur, fill_hit;
  logic [4:0]    sh;
  logic [31:0]   src, shifted;

  assign cur_tag  = addr_i[AW-1:LSB];
  assign fill_tag = fill_addr_i[AW-1:LSB];
  assign hit_cur  = valid_q && (tag_q == cur_tag);
  // The line being written this cycle counts as a hit so ok rises right after FILL.
  assign fill_hit = fill_i && (fill_tag == cur_tag);
  assign miss_o   = cs_i && !hit_cur;

  always_comb begin
    sh      = BYTE_SLOT ? {addr_i[1:0], 3'b000} : 5'd0;
    src     = fill_hit ? fill_data_i : data_q;
    shifted = src >> sh;
    dout_d  = shifted[DW-1:0];
    ok_d    = cs_i && ((hit_cur && !clr_i) || fill_hit);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      ok_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      // A fill wins over an invalidate so an in-flight fetch still lands.
      if (fill_i) begin
        valid_q <= 1'b1;
        tag_q   <= fill_tag;
        data_q  <= fill_data_i;
      end else if (clr_i) begin
        valid_q <= 1'b0;
      end
      ok_q <= ok_d;
      if (ok_d) dout_q <= dout_d;
    end
  end

  assign ok_o   = ok_q;
  assign dout_o = dout_q;

endmodule

// File: rtl/jtbubl_romarb.sv
// Five-slot SDRAM read scheduler: main, sub, MCU, sound and gfx ROM requesters
// share one SDRAM read port, each keeping one 32-bit cache line.
//   clk, rst                 : SDRAM clock, synchronous active-high reset
//   vblank, downloading      : video blank, ROM download in progress
//   loop_rst                 : invalidate every line
//   slotN_cs/addr/ok/dout    : requester ports, N=0..4
//   sdram_req/ack/addr       : fetch handshake towards the SDRAM controller
//   data_rdy, data_read      : returned 32-bit line
//   refresh_en               : controller may refresh
//   st_dbg                   : arbiter state, for observation
// Handshake: sdram_req is held high in REQ until the cycle sdram_ack is seen
// high; the transfer is accepted on that cycle. data_rdy is then a one-cycle
// strobe qualifying data_read, honoured only in WAIT.
// Build option JTBUBL_GFXPRIO_EN: gfx slot first while vblank is low, last during
// vblank. Undefined: fixed order slot0..slot4, vblank unused.
module jtbubl_romarb
  import jtbubl_pkg::*;
#(
  parameter int          SLOT0_AW     = 18,
  parameter int          SLOT1_AW     = 15,
  parameter int          SLOT2_AW     = 12,
  parameter int          SLOT3_AW     = 15,
  parameter int          SLOT4_AW     = 18,
  parameter logic [21:0] SLOT0_OFFSET = SLOT0_OFFSET_DEF,
  parameter logic [21:0] SLOT1_OFFSET = SLOT1_OFFSET_DEF,
  parameter logic [21:0] SLOT2_OFFSET = SLOT2_OFFSET_DEF,
  parameter logic [21:0] SLOT3_OFFSET = SLOT3_OFFSET_DEF,
  parameter logic [21:0] SLOT4_OFFSET = SLOT4_OFFSET_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vblank,
  input  logic                downloading,
  input  logic                loop_rst,
  input  logic                slot0_cs,
  input  logic                slot1_cs,
  input  logic                slot2_cs,
  input  logic                slot3_cs,
  input  logic                slot4_cs,
  input  logic [SLOT0_AW-1:0] slot0_addr,
  input  logic [SLOT1_AW-1:0] slot1_addr,
  input  logic [SLOT2_AW-1:0] slot2_addr,
  input  logic [SLOT3_AW-1:0] slot3_addr,
  input  logic [SLOT4_AW-1:0] slot4_addr,
  output logic                slot0_ok,
  output logic                slot1_ok,
  output logic                slot2_ok,
  output logic                slot3_ok,
  output logic                slot4_ok,
  output logic [7:0]          slot0_dout,
  output logic [7:0]          slot1_dout,
  output logic [7:0]          slot2_dout,
  output logic [7:0]          slot3_dout,
  output logic [31:0]         slot4_dout,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  output logic [21:0]         sdram_addr,
  input  logic [31:0]         data_read,
  output logic                refresh_en,
  output logic [1:0]          st_dbg
);

  arb_state_e        st_q, st_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [REQ_AW-1:0] raddr_q, raddr_d;
  logic [21:0]       saddr_q, saddr_d;
  logic [31:0]       rdata_q;

  logic [SLOT_CNT-1:0] miss, fill;
  logic                any_miss, clr;
  logic [2:0]          pick;
  logic [REQ_AW-1:0]   pick_raddr;
  logic [21:0]         pick_saddr;

  assign any_miss = |miss;
  assign clr      = downloading || loop_rst;

`ifndef JTBUBL_GFXPRIO_EN
  logic unused_vblank;
  assign unused_vblank = vblank;
`endif

  always_comb begin
    pick = 3'd4;
    for (int k = SLOT_CNT - 1; k >= 0; k--) begin
      if (miss[k]) pick = 3'(k);
    end
`ifdef JTBUBL_GFXPRIO_EN
    if (!vblank && miss[4]) pick = 3'd4;
`endif
  end

  always_comb begin
    pick_raddr = REQ_AW'(slot4_addr);
    pick_saddr = sdram_word(SLOT4_OFFSET, 22'(slot4_addr));
    case (pick)
      3'd0: begin
        pick_raddr = REQ_AW'(slot0_addr);
        pick_saddr = sdram_word(SLOT0_OFFSET, 22'(slot0_addr[SLOT0_AW-1:2]));
      end
      3'd1: begin
        pick_raddr = REQ_AW'(slot1_addr);
        pick_saddr = sdram_word(SLOT1_OFFSET, 22'(slot1_addr[SLOT1_AW-1:2]));
      end
      3'd2: begin
        pick_raddr = REQ_AW'(slot2_addr);
        pick_saddr = sdram_word(SLOT2_OFFSET, 22'(slot2_addr[SLOT2_AW-1:2]));
      end
      3'd3: begin
        pick_raddr = REQ_AW'(slot3_addr);
        pick_saddr = sdram_word(SLOT3_OFFSET, 22'(slot3_addr[SLOT3_AW-1:2]));
      end
      default: ;
    endcase
  end

  always_comb begin
    st_d    = st_q;
    gnt_d   = gnt_q;
    raddr_d = raddr_q;
    saddr_d = saddr_q;
    if (downloading) begin
      st_d = ST_IDLE;
    end else begin
      case (st_q)
        ST_IDLE: if (any_miss) begin
          gnt_d   = pick;
          raddr_d = pick_raddr;
          saddr_d = pick_saddr;
          st_d    = ST_REQ;
        end
        ST_REQ:  if (sdram_ack) st_d = ST_WAIT;
        ST_WAIT: if (data_rdy) st_d = ST_FILL;
        ST_FILL: st_d = ST_IDLE;
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      gnt_q   <= '0;
      raddr_q <= '0;
      saddr_q <= '0;
      rdata_q <= '0;
    end else begin
      st_q    <= st_d;
      gnt_q   <= gnt_d;
      raddr_q <= raddr_d;
      saddr_q <= saddr_d;
      if (st_q == ST_WAIT && data_rdy) rdata_q <= data_read;
    end
  end

  // Fill is suppressed while downloading so an aborted fetch leaves no trace.
  always_comb begin
    for (int k = 0; k < SLOT_CNT; k++) begin
      fill[k] = (st_q == ST_FILL) && !downloading && (gnt_q == 3'(k));
    end
  end

  assign sdram_req  = (st_q == ST_REQ) && !downloading;
  assign sdram_addr = saddr_q;
  assign refresh_en = downloading || (st_q == ST_IDLE && !any_miss);
  assign st_dbg     = st_q;

  jtbubl_romarb_line #(.AW(SLOT0_AW), .DW(8)) u_line0 (
    .clk_i(clk), .rst_i(rst), .cs_i(slot0_cs), .addr_i(slot0_addr), .clr_i(clr),
    .fill_i(fill[0]), .fill_addr_i(raddr_q[SLOT0_AW-1:0]), .fill_data_i(rdata_q),
    .miss_o(miss[0]), .ok_o(slot0_ok), .dout_o(slot0_dout)
  );

  jtbubl_romarb_line #(.AW(SLOT1_AW), .DW(8)) u_line1 (
    .clk_i(clk), .rst_i(rst), .cs_i(slot1_cs), .addr_i(slot1_addr), .clr_i(clr),
    .fill_i(fill[1]), .fill_addr_i(raddr_q[SLOT1_AW-1:0]), .fill_data_i(rdata_q),
    .miss_o(miss[1]), .ok_o(slot1_ok), .dout_o(slot1_dout)
  );

  jtbubl_romarb_line #(.AW(SLOT2_AW), .DW(8)) u_line2 (
    .clk_i(clk), .rst_i(rst), .cs_i(slot2_cs), .addr_i(slot2_addr), .clr_i(clr),
    .fill_i(fill[2]), .fill_addr_i(raddr_q[SLOT2_AW-1:0]), .fill_data_i(rdata_q),
    .miss_o(miss[2]), .ok_o(slot2_ok), .dout_o(slot2_dout)
  );

  jtbubl_romarb_line #(.AW(SLOT3_AW), .DW(8)) u_line3 (
    .clk_i(clk), .rst_i(rst), .cs_i(slot3_cs), .addr_i(slot3_addr), .clr_i(clr),
    .fill_i(fill[3]), .fill_addr_i(raddr_q[SLOT3_AW-1:0]), .fill_data_i(rdata_q),
    .miss_o(miss[3]), .ok_o(slot3_ok), .dout_o(slot3_dout)
  );

  jtbubl_romarb_line #(.AW(SLOT4_AW), .DW(32)) u_line4 (
    .clk_i(clk), .rst_i(rst), .cs_i(slot4_cs), .addr_i(slot4_addr), .clr_i(clr),
    .fill_i(fill[4]), .fill_addr_i(raddr_q[SLOT4_AW-1:0]), .fill_data_i(rdata_q),
    .miss_o(miss[4]), .ok_o(slot4_ok), .dout_o(slot4_dout)
  );

endmodule
